// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver/transmitter pair.
package uart_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 868;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Capture the async input, then re-register to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with mid-bit sampling and valid/ready output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter bit          MSB_FIRST    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 complete;

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame sequencing plus output handshake / overrun resolution.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    complete = 1'b0;

    if (valid_q && rx_ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          baud_d  = '0;
        end
      end
      START: begin
        if (baud_q == HALF_M1) begin
          baud_d = '0;
          idx_d  = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d = '0;
          idx_d  = idx_q + 3'd1;
          if (MSB_FIRST) shift_d = {shift_q[DATA_BITS-2:0], rx_s};
          else           shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d = '0;
          if (rx_s) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle transfer frees the holding register for the new byte.
    if (complete) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx using a frame-level event model.
module tb_uart_rx;

  localparam int unsigned CPB = 16;
  localparam int unsigned LAT = 154;  // first edge seeing start low -> rx_valid

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rx_l = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data, rx_data_l;
  logic       rx_valid, rx_valid_l;
  logic       frame_err, frame_err_l;
  logic       overrun, overrun_l;
  logic       busy, busy_l;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .rx(rx_l), .rx_ready(1'b1),
    .rx_data(rx_data_l), .rx_valid(rx_valid_l), .frame_err(frame_err_l),
    .overrun(overrun_l), .busy(busy_l)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned t;
    bit          ferr;
    logic [7:0]  d;
  } ev_t;
  ev_t evq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: expected completions arrive at known cycles.
  logic        m_valid = 1'b0, m_prev;
  logic [7:0]  m_data = '0;
  logic        m_ferr = 1'b0, m_ovr = 1'b0;
  ev_t         cur;
  int unsigned ferr_seen = 0, ovr_seen = 0, busy_hi = 0;
  int unsigned rise_cyc = 0, rise_l_cyc = 0;
  logic [7:0]  rise_data = '0, rise_l_data = '0;
  logic        dv_prev = 1'b0, dvl_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      m_valid = 1'b0; m_data = '0; m_ferr = 1'b0; m_ovr = 1'b0;
      evq.delete();
      chk("busy_in_reset", busy, 1'b0);
    end else begin
      m_prev = m_valid;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (m_prev && rx_ready) m_valid = 1'b0;
      if (evq.size() > 0 && evq[0].t == cyc) begin
        cur = evq.pop_front();
        if (cur.ferr) m_ferr = 1'b1;
        else if (!m_prev || rx_ready) begin
          m_data  = cur.d;
          m_valid = 1'b1;
        end else m_ovr = 1'b1;
      end
    end
    chk("rx_valid", rx_valid, m_valid);
    chk("rx_data", rx_data, m_data);
    chk("frame_err", frame_err, m_ferr);
    chk("overrun", overrun, m_ovr);
    if (frame_err) ferr_seen++;
    if (overrun) ovr_seen++;
    if (busy) busy_hi++;
    if (rx_valid && !dv_prev) begin rise_cyc = cyc; rise_data = rx_data; end
    if (rx_valid_l && !dvl_prev) begin rise_l_cyc = cyc; rise_l_data = rx_data_l; end
    dv_prev  = rx_valid;
    dvl_prev = rx_valid_l;
  end

  task automatic send(input logic [7:0] b, input bit stop, input bit lsb, input bit sel,
                      output int unsigned t0);
    logic v;
    ev_t  e;
    t0 = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) v = 1'b0;
      else if (k == 9) v = stop;
      else v = lsb ? b[k-1] : b[8-k];
      for (int j = 0; j < int'(CPB); j++) begin
        @(negedge clk);
        if (sel) rx_l = v; else rx = v;
        if (k == 0 && j == 0) begin
          t0 = cyc + 1;
          if (!sel) begin
            e.t = t0 + LAT; e.ferr = !stop; e.d = b;
            evq.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk) rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  int unsigned t0;
  ev_t         be;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", rx_data, 8'h00);
    @(negedge clk) rst = 1'b1;
    idle(20);

    // 0xA5 MSB first with latency pin, then LSB-first instance
    rx_ready = 1'b1;
    send(8'hA5, 1'b1, 1'b0, 1'b0, t0);
    idle(10);
    chk("a5_latency", rise_cyc, t0 + LAT);
    chk("a5_data", rise_data, 8'hA5);
    send(8'hA5, 1'b1, 1'b1, 1'b1, t0);
    repeat (10) @(negedge clk);
    chk("lsb_latency", rise_l_cyc, t0 + LAT);
    chk("lsb_data", rise_l_data, 8'hA5);
    chk("lsb_no_ferr", frame_err_l, 1'b0);

    // 5-cycle glitch
    idle(20);
    busy_hi = 0;
    repeat (5) @(negedge clk) rx = 1'b0;
    idle(40);
    chk("glitch_busy_le8", (busy_hi >= 1 && busy_hi <= 8), 1'b1);
    chk("glitch_busy_end", busy, 1'b0);

    // Stop bit low, then break, then recovery
    ferr_seen = 0;
    send(8'h3C, 1'b0, 1'b0, 1'b0, t0);
    idle(30);
    chk("ferr_once", ferr_seen, 1);
    chk("ferr_novalid", rx_valid, 1'b0);
    ferr_seen = 0;
    @(negedge clk) rx = 1'b0;
    be.t = cyc + 1 + LAT; be.ferr = 1'b1; be.d = 8'h00;
    evq.push_back(be);
    repeat (100 * CPB - 1) @(negedge clk);
    chk("break_busy", busy, 1'b1);
    idle(40);
    chk("break_ferr_once", ferr_seen, 1);
    send(8'h81, 1'b1, 1'b0, 1'b0, t0);
    idle(10);
    chk("after_break_data", rise_data, 8'h81);
    chk("after_break_cyc", rise_cyc, t0 + LAT);

    // Overrun: 0x11 then 0x22 back-to-back, consumer stalled
    rx_ready = 1'b0;
    ovr_seen = 0;
    send(8'h11, 1'b1, 1'b0, 1'b0, t0);
    send(8'h22, 1'b1, 1'b0, 1'b0, t0);
    idle(20);
    chk("ovr_once", ovr_seen, 1);
    chk("ovr_held_data", rx_data, 8'h11);
    chk("ovr_held_valid", rx_valid, 1'b1);
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
    chk("ovr_drained", rx_valid, 1'b0);

    // Transfer and completion in the same cycle
    ovr_seen = 0;
    send(8'h55, 1'b1, 1'b0, 1'b0, t0);
    idle(10);
    chk("hold_55", rx_data, 8'h55);
    fork
      send(8'h66, 1'b1, 1'b0, 1'b0, t0);
      begin
        @(negedge clk);
        repeat (LAT) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk) rx_ready = 1'b0;
      end
    join
    idle(5);
    chk("swap_data", rx_data, 8'h66);
    chk("swap_valid", rx_valid, 1'b1);
    chk("swap_no_ovr", ovr_seen, 0);

    // Reset during data bit 4 of 0xF0
    rx_ready = 1'b1;
    idle(5);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < int'(CPB); j++) begin
        @(negedge clk);
        rx = (k == 0) ? 1'b0 : 1'b1;
        if (k == 4 && j == 0) rx = 1'b0;
      end
    end
    @(negedge clk) begin rx = 1'b0; end
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    @(negedge clk) begin rst = 1'b0; rx = 1'b1; end
    repeat (3) @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_data", rx_data, 8'h00);
    chk("midrst_valid", rx_valid, 1'b0);
    @(negedge clk) rst = 1'b1;
    idle(20);
    send(8'h0F, 1'b1, 1'b0, 1'b0, t0);
    idle(10);
    chk("post_rst_data", rise_data, 8'h0F);
    chk("post_rst_cyc", rise_cyc, t0 + LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
